// File: rtl/text_write_sequencer.sv
// Cursor-tracking write sequencer for the VGA text RAM: one registered RAM write per accepted byte,
// full-screen clear at one cell per cycle, and a one-deep echo slot that waits out tx_busy.
module text_write_sequencer #(
    parameter int COLS     = 32,
    parameter int ROWS     = 4,
    parameter int HOME_ROW = 1,
    parameter int HOME_COL = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    input  logic                    clear_req,
    input  logic                    tx_busy,
    output logic                    ram_we,
    output logic [$clog2(ROWS)-1:0] ram_row,
    output logic [$clog2(COLS)-1:0] ram_col,
    output logic [7:0]              ram_wdata,
    output logic [$clog2(ROWS)-1:0] cur_row,
    output logic [$clog2(COLS)-1:0] cur_col,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    output logic                    busy,
    output logic [7:0]              drop_cnt
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int AW = RW + CW;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0] state;
    logic       echo_pending;
    logic [7:0] echo_buf;

    logic          is_print;
    logic          is_newline;
    logic          is_bs;
    logic          is_ff;
    logic          accept;
    logic          start_clear;
    logic          drop;
    logic          echo_new;
    logic          echo_issue;
    logic [7:0]    echo_byte;
    logic [CW-1:0] adv_col;
    logic [RW-1:0] adv_row;
    logic [AW-1:0] clr_next;
    logic          clr_last;

    always_comb begin
        is_print    = (rx_data >= 8'h20) && (rx_data <= 8'h7E);
        is_newline  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
        is_bs       = (rx_data == 8'h08);
        is_ff       = (rx_data == 8'h0C);
        // A byte arriving together with clear_req loses to the clear.
        accept      = rx_valid && (state == IDLE) && !clear_req;
        start_clear = (state == IDLE) && (clear_req || (accept && is_ff));
        drop        = rx_valid && ((state == CLEAR) || clear_req);
        echo_new    = accept && (is_print || is_newline || is_bs);
        echo_issue  = (echo_new || echo_pending) && !tx_busy && !tx_start;
        echo_byte   = echo_new ? rx_data : echo_buf;
        adv_col     = cur_col + CW'(1);
        adv_row     = (cur_col == '1) ? cur_row + RW'(1) : cur_row;
        clr_next    = {ram_row, ram_col} + AW'(1);
        clr_last    = ({ram_row, ram_col} == '1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ram_we       <= 1'b0;
            ram_row      <= '0;
            ram_col      <= '0;
            ram_wdata    <= 8'h00;
            cur_row      <= RW'(HOME_ROW);
            cur_col      <= CW'(HOME_COL);
            tx_start     <= 1'b0;
            tx_data      <= 8'h00;
            busy         <= 1'b0;
            drop_cnt     <= 8'h00;
            echo_pending <= 1'b0;
            echo_buf     <= 8'h00;
        end else begin
            ram_we   <= 1'b0;
            tx_start <= 1'b0;

            if (echo_issue) begin
                tx_start     <= 1'b1;
                tx_data      <= echo_byte;
                echo_pending <= 1'b0;
            end else if (echo_new) begin
                echo_buf     <= rx_data;
                echo_pending <= 1'b1;
            end

            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (start_clear) begin
                        state     <= CLEAR;
                        busy      <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_row   <= '0;
                        ram_col   <= '0;
                        ram_wdata <= 8'h20;
                    end else if (accept && is_print) begin
                        ram_we    <= 1'b1;
                        ram_row   <= cur_row;
                        ram_col   <= cur_col;
                        ram_wdata <= rx_data;
                        cur_row   <= adv_row;
                        cur_col   <= adv_col;
                    end else if (accept && is_newline) begin
                        cur_row <= cur_row + RW'(1);
                        cur_col <= '0;
                    end else if (accept && is_bs && (cur_col != '0)) begin
                        ram_we    <= 1'b1;
                        ram_row   <= cur_row;
                        ram_col   <= cur_col - CW'(1);
                        ram_wdata <= 8'h20;
                        cur_col   <= cur_col - CW'(1);
                    end
                end
                default: begin
                    // The RAM address register doubles as the clear sweep counter.
                    if (clr_last) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        cur_row <= RW'(HOME_ROW);
                        cur_col <= CW'(HOME_COL);
                    end else begin
                        ram_we               <= 1'b1;
                        {ram_row, ram_col}   <= clr_next;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_write_sequencer.sv
// Bench for text_write_sequencer: vector table, hand-written clear/echo/reset
// sequences, and a randomized run against a cursor/screen reference model.
module tb_text_write_sequencer;

    localparam int COLS = 32;
    localparam int ROWS = 4;
    localparam int HOME_ROW = 1;
    localparam int HOME_COL = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       clear_req;
    logic       tx_busy;
    logic       ram_we;
    logic [1:0] ram_row;
    logic [4:0] ram_col;
    logic [7:0] ram_wdata;
    logic [1:0] cur_row;
    logic [4:0] cur_col;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic [7:0] drop_cnt;

    text_write_sequencer #(
        .COLS(COLS), .ROWS(ROWS), .HOME_ROW(HOME_ROW), .HOME_COL(HOME_COL)
    ) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .clear_req(clear_req), .tx_busy(tx_busy), .ram_we(ram_we),
        .ram_row(ram_row), .ram_col(ram_col), .ram_wdata(ram_wdata),
        .cur_row(cur_row), .cur_col(cur_col), .tx_start(tx_start),
        .tx_data(tx_data), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs; returns at the following negedge with strobes cleared.
    task automatic cyc(input logic v, input logic [7:0] d, input logic c, input logic b);
        rx_valid  = v;
        rx_data   = d;
        clear_req = c;
        tx_busy   = b;
        @(negedge clk);
        rx_valid  = 1'b0;
        clear_req = 1'b0;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0; rx_data = 8'h00; clear_req = 1'b0; tx_busy = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_write(input string tag, input int row, input int col, input int wd);
        check({tag, "_we"}, 32'(ram_we), 32'd1);
        check({tag, "_row"}, 32'(ram_row), 32'(row));
        check({tag, "_col"}, 32'(ram_col), 32'(col));
        check({tag, "_wdata"}, 32'(ram_wdata), 32'(wd));
    endtask

    task automatic check_cursor(input string tag, input int row, input int col);
        check({tag, "_cur_row"}, 32'(cur_row), 32'(row));
        check({tag, "_cur_col"}, 32'(cur_col), 32'(col));
    endtask

    typedef struct {
        logic       rv;
        logic [7:0] rd;
        logic       tb;
        logic       we;
        logic [1:0] row;
        logic [4:0] col;
        logic [7:0] wd;
        logic [1:0] crow;
        logic [4:0] ccol;
        logic       txs;
        logic [7:0] txd;
    } vec_t;

    function automatic vec_t mk(input int rv, input int rd, input int tb, input int we,
                                input int row, input int col, input int wd, input int crow,
                                input int ccol, input int txs, input int txd);
        vec_t v;
        v.rv = 1'(rv); v.rd = 8'(rd); v.tb = 1'(tb); v.we = 1'(we);
        v.row = 2'(row); v.col = 5'(col); v.wd = 8'(wd);
        v.crow = 2'(crow); v.ccol = 5'(ccol); v.txs = 1'(txs); v.txd = 8'(txd);
        return v;
    endfunction

    // Reference model state (plain integers, linear screen positions).
    int m_row, m_col, m_busy, m_idx, m_pend, m_buf, m_txs, m_txd, m_drop;
    int m_we, m_wrow, m_wcol, m_wd;

    task automatic model_reset();
        m_row = HOME_ROW; m_col = HOME_COL; m_busy = 0; m_idx = 0; m_pend = 0;
        m_buf = 0; m_txs = 0; m_txd = 0; m_drop = 0;
        m_we = 0; m_wrow = 0; m_wcol = 0; m_wd = 0;
    endtask

    task automatic model_write(input int row, input int col, input int wd);
        m_we = 1; m_wrow = row; m_wcol = col; m_wd = wd;
    endtask

    task automatic model_step(input int rv, input int rd, input int cr, input int tb);
        int prt, nl, bs, echo, was_busy, pos;
        was_busy = m_busy;
        prt  = (rd >= 'h20 && rd <= 'h7E) ? 1 : 0;
        nl   = (rd == 'h0D || rd == 'h0A) ? 1 : 0;
        bs   = (rd == 'h08) ? 1 : 0;
        echo = (rv != 0 && was_busy == 0 && cr == 0 && (prt + nl + bs) != 0) ? 1 : 0;
        m_we = 0;
        if (rv != 0 && (was_busy != 0 || cr != 0) && m_drop < 255) m_drop++;
        if (was_busy != 0) begin
            if (m_idx == ROWS * COLS - 1) begin
                m_busy = 0; m_row = HOME_ROW; m_col = HOME_COL;
            end else begin
                m_idx++;
                model_write(m_idx / COLS, m_idx % COLS, 'h20);
            end
        end else if (cr != 0 || (rv != 0 && rd == 'h0C)) begin
            m_busy = 1; m_idx = 0;
            model_write(0, 0, 'h20);
        end else if (rv != 0 && prt != 0) begin
            model_write(m_row, m_col, rd);
            pos = (m_row * COLS + m_col + 1) % (ROWS * COLS);
            m_row = pos / COLS; m_col = pos % COLS;
        end else if (rv != 0 && nl != 0) begin
            m_col = 0; m_row = (m_row + 1) % ROWS;
        end else if (rv != 0 && bs != 0 && m_col > 0) begin
            m_col--;
            model_write(m_row, m_col, 'h20);
        end
        if ((echo != 0 || m_pend != 0) && tb == 0 && m_txs == 0) begin
            m_txs = 1; m_txd = (echo != 0) ? rd : m_buf; m_pend = 0;
        end else begin
            m_txs = 0;
            if (echo != 0) begin m_buf = rd; m_pend = 1; end
        end
    endtask

    initial begin
        vec_t vt[18];
        logic [7:0] rd;
        logic rv, cr, tb;

        vt[0]  = mk(1, 'h41, 0, 1, 1, 0, 'h41, 1, 1, 1, 'h41);
        vt[1]  = mk(0, 'h00, 0, 0, 0, 0, 0,    1, 1, 0, 'h41);
        vt[2]  = mk(1, 'h42, 0, 1, 1, 1, 'h42, 1, 2, 1, 'h42);
        vt[3]  = mk(1, 'h43, 0, 1, 1, 2, 'h43, 1, 3, 0, 'h42);
        vt[4]  = mk(0, 'h00, 0, 0, 0, 0, 0,    1, 3, 1, 'h43);
        vt[5]  = mk(1, 'h08, 0, 1, 1, 2, 'h20, 1, 2, 0, 'h43);
        vt[6]  = mk(0, 'h00, 0, 0, 0, 0, 0,    1, 2, 1, 'h08);
        vt[7]  = mk(1, 'h0D, 0, 0, 0, 0, 0,    2, 0, 0, 'h08);
        vt[8]  = mk(1, 'h08, 0, 0, 0, 0, 0,    2, 0, 1, 'h08);
        vt[9]  = mk(1, 'h07, 0, 0, 0, 0, 0,    2, 0, 0, 'h08);
        vt[10] = mk(0, 'h00, 0, 0, 0, 0, 0,    2, 0, 0, 'h08);
        vt[11] = mk(1, 'h0A, 0, 0, 0, 0, 0,    3, 0, 1, 'h0A);
        vt[12] = mk(1, 'h80, 0, 0, 0, 0, 0,    3, 0, 0, 'h0A);
        vt[13] = mk(1, 'h7E, 0, 1, 3, 0, 'h7E, 3, 1, 1, 'h7E);
        vt[14] = mk(1, 'h20, 1, 1, 3, 1, 'h20, 3, 2, 0, 'h7E);
        vt[15] = mk(0, 'h00, 1, 0, 0, 0, 0,    3, 2, 0, 'h7E);
        vt[16] = mk(0, 'h00, 0, 0, 0, 0, 0,    3, 2, 1, 'h20);
        vt[17] = mk(0, 'h00, 0, 0, 0, 0, 0,    3, 2, 0, 'h20);

        @(negedge clk);
        do_reset();
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_row", 32'(ram_row), 32'd0);
        check("rst_col", 32'(ram_col), 32'd0);
        check("rst_wdata", 32'(ram_wdata), 32'd0);
        check_cursor("rst", HOME_ROW, HOME_COL);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);

        for (int i = 0; i < 18; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            cyc(vt[i].rv, vt[i].rd, 1'b0, vt[i].tb);
            check({tag, "_we"}, 32'(ram_we), 32'(vt[i].we));
            if (vt[i].we) begin
                check({tag, "_row"}, 32'(ram_row), 32'(vt[i].row));
                check({tag, "_col"}, 32'(ram_col), 32'(vt[i].col));
                check({tag, "_wdata"}, 32'(ram_wdata), 32'(vt[i].wd));
            end
            check_cursor(tag, int'(vt[i].crow), int'(vt[i].ccol));
            check({tag, "_tx_start"}, 32'(tx_start), 32'(vt[i].txs));
            check({tag, "_tx_data"}, 32'(tx_data), 32'(vt[i].txd));
        end

        // Bottom-right wrap, then CR, then backspace in mid-row.
        do_reset();
        cyc(1'b1, 8'h0A, 1'b0, 1'b0);
        cyc(1'b1, 8'h0A, 1'b0, 1'b0);
        for (int i = 0; i < 31; i++) cyc(1'b1, 8'h61, 1'b0, 1'b0);
        check_cursor("wrap_pre", 3, 31);
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        check_write("wrap_z", 3, 31, 'h5A);
        check_cursor("wrap_z", 0, 0);
        cyc(1'b1, 8'h0D, 1'b0, 1'b0);
        check("cr_we", 32'(ram_we), 32'd0);
        check_cursor("cr", 1, 0);
        cyc(1'b1, 8'h0A, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h62, 1'b0, 1'b0);
        cyc(1'b1, 8'h08, 1'b0, 1'b0);
        check_write("bs_mid", 2, 4, 'h20);
        check_cursor("bs_mid", 2, 4);

        // Full clear with drops and an ignored clear_req.
        do_reset();
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < ROWS * COLS; i++) begin
            if (i > 0) cyc(i == 10 || i == 60 || i == 127, 8'h41, i == 50, 1'b0);
            check_write($sformatf("clr%0d", i), i / COLS, i % COLS, 'h20);
            check($sformatf("clr%0d_busy", i), 32'(busy), 32'd1);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("clr_end_we", 32'(ram_we), 32'd0);
        check("clr_end_busy", 32'(busy), 32'd0);
        check_cursor("clr_end", HOME_ROW, HOME_COL);
        check("clr_end_drop", 32'(drop_cnt), 32'd3);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("clr_after_we", 32'(ram_we), 32'd0);

        // Echo held off by tx_busy; newest byte wins.
        do_reset();
        cyc(1'b1, 8'h78, 1'b0, 1'b1);
        check_write("hold_x", 1, 0, 'h78);
        check("hold_x_txs", 32'(tx_start), 32'd0);
        cyc(1'b1, 8'h79, 1'b0, 1'b1);
        check_write("hold_y", 1, 1, 'h79);
        check("hold_y_txs", 32'(tx_start), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("hold_idle_txs", 32'(tx_start), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("release_txs", 32'(tx_start), 32'd1);
        check("release_txd", 32'(tx_data), 32'h79);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("release_once", 32'(tx_start), 32'd0);

        // Reset in the middle of a clear.
        do_reset();
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 1; i < 40; i++) cyc(i == 5, 8'h41, 1'b0, 1'b0);
        check("midclr_we", 32'(ram_we), 32'd1);
        check("midclr_drop", 32'(drop_cnt), 32'd1);
        reset = 1'b1;
        #1;
        check("arst_we", 32'(ram_we), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check_cursor("arst", HOME_ROW, HOME_COL);
        check("arst_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_arst_we", 32'(ram_we), 32'd0);
        cyc(1'b1, 8'h51, 1'b0, 1'b0);
        check_write("post_arst_q", 1, 0, 'h51);
        check_cursor("post_arst_q", 1, 1);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        tb = 1'b0;
        for (int n = 0; n < 6000; n++) begin
            string tag;
            tag = $sformatf("rnd%0d", n);
            check({tag, "_we"}, 32'(ram_we), 32'(m_we));
            if (m_we != 0) begin
                check({tag, "_row"}, 32'(ram_row), 32'(m_wrow));
                check({tag, "_col"}, 32'(ram_col), 32'(m_wcol));
                check({tag, "_wdata"}, 32'(ram_wdata), 32'(m_wd));
            end
            check_cursor(tag, m_row, m_col);
            check({tag, "_txs"}, 32'(tx_start), 32'(m_txs));
            check({tag, "_txd"}, 32'(tx_data), 32'(m_txd));
            check({tag, "_busy"}, 32'(busy), 32'(m_busy));
            check({tag, "_drop"}, 32'(drop_cnt), 32'(m_drop));

            rv = (m_busy != 0) ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 1) == 1);
            cr = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) tb = ~tb;
            case ($urandom_range(0, 19))
                12: rd = 8'h0D;
                13: rd = 8'h0A;
                14, 15: rd = 8'h08;
                16: rd = ($urandom_range(0, 3) == 0) ? 8'h0C : 8'h2E;
                17: rd = 8'($urandom_range(0, 255));
                default: rd = 8'($urandom_range(32, 126));
            endcase
            model_step(int'(rv), int'(rd), int'(cr), int'(tb));
            cyc(rv, rd, cr, tb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
